// File: rtl/weight_updater_pkg.sv
// Shared helpers for the weight update stage.
// State encodings, width helpers and signed saturation.
package weight_updater_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Counters never collapse to zero width, even for a single row/column.
    function automatic int cnt_width(input int value);
        int r;
        r = clog2(value);
        return (r > 0) ? r : 1;
    endfunction

    function automatic logic signed [31:0] saturate(
        input logic signed [31:0] value,
        input int                 width
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/weight_update_cell.sv
// Combinational datapath: delta*activation product, learning-rate
// shift, weight add and saturation with an overflow indication.
module weight_update_cell
    import weight_updater_pkg::*;
#(
    parameter int DELTA_WIDTH  = 10,
    parameter int ACT_WIDTH    = 9,
    parameter int WEIGHT_WIDTH = 16,
    parameter int SHIFT        = 3,
    parameter int PROD_WIDTH   = DELTA_WIDTH + ACT_WIDTH + 1
) (
    input  logic signed [DELTA_WIDTH-1:0]  delta_i,
    input  logic        [ACT_WIDTH-1:0]    act_i,
    output logic signed [PROD_WIDTH-1:0]   prod_o,
    input  logic signed [PROD_WIDTH-1:0]   prod_i,
    input  logic signed [WEIGHT_WIDTH-1:0] weight_i,
    output logic signed [WEIGHT_WIDTH-1:0] weight_o,
    output logic                           ovf_o
);

    localparam int SW = ((PROD_WIDTH > WEIGHT_WIDTH) ? PROD_WIDTH : WEIGHT_WIDTH) + 1;

    logic signed [PROD_WIDTH-1:0] d_ext;
    logic signed [PROD_WIDTH-1:0] a_ext;
    logic signed [PROD_WIDTH-1:0] upd;
    logic signed [SW-1:0]         sum;
    logic signed [31:0]           sum_w;
    logic signed [31:0]           sat;

    // Activation is unsigned, so it is zero-extended before the signed multiply.
    assign d_ext  = {{(PROD_WIDTH - DELTA_WIDTH){delta_i[DELTA_WIDTH-1]}}, delta_i};
    assign a_ext  = {{(PROD_WIDTH - ACT_WIDTH){1'b0}}, act_i};
    assign prod_o = d_ext * a_ext;

    assign upd   = prod_i >>> SHIFT;
    assign sum   = SW'(weight_i) + SW'(upd);
    assign sum_w = 32'(sum);
    assign sat   = saturate(sum_w, WEIGHT_WIDTH);

    assign weight_o = sat[WEIGHT_WIDTH-1:0];
    assign ovf_o    = (sat != sum_w);

endmodule

// File: rtl/weight_updater.sv
// weight_updater: applies the outer-product gradient step to every
// weight once through a read / multiply / add-and-write pipeline.
module weight_updater
    import weight_updater_pkg::*;
#(
    parameter int NEURON_NUM        = 5,
    parameter int INPUT_NUM         = 5,
    parameter int DELTA_CELL_WIDTH  = 10,
    parameter int ACTIVATION_WIDTH  = 9,
    parameter int WEIGHT_CELL_WIDTH = 16,
    parameter int FRACTION_WIDTH    = 0,
    parameter int LEARN_RATE_SHIFT  = 3,
    parameter int ADDR_WIDTH        = clog2(NEURON_NUM * INPUT_NUM)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NEURON_NUM*DELTA_CELL_WIDTH-1:0] delta,
    input  logic                                   delta_valid,
    output logic                                   delta_ready,
    input  logic [INPUT_NUM*ACTIVATION_WIDTH-1:0]  a,
    input  logic                                   a_valid,
    output logic                                   a_ready,
    output logic                                   w_rd_en,
    output logic [ADDR_WIDTH-1:0]                  w_rd_addr,
    input  logic [WEIGHT_CELL_WIDTH-1:0]           w_rd_data,
    output logic                                   w_wr_en,
    output logic [ADDR_WIDTH-1:0]                  w_wr_addr,
    output logic [WEIGHT_CELL_WIDTH-1:0]           w_wr_data,
    output logic                                   done,
    output logic                                   error
);

    localparam int DW = DELTA_CELL_WIDTH;
    localparam int AW = ACTIVATION_WIDTH;
    localparam int WW = WEIGHT_CELL_WIDTH;
    localparam int PW = DW + AW + 1;
    localparam int T  = NEURON_NUM * INPUT_NUM;
    localparam int NW = cnt_width(NEURON_NUM);
    localparam int IW = cnt_width(INPUT_NUM);

    logic [1:0]             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  k_q, k_d;
    logic [NW-1:0]          n_q, n_d;
    logic [IW-1:0]          i_q, i_d;
    logic [NEURON_NUM*DW-1:0] delta_q, delta_d;
    logic [INPUT_NUM*AW-1:0]  a_q, a_d;
    logic                   error_q;

    logic                   s2_vld_q;
    logic [ADDR_WIDTH-1:0]  s2_addr_q;
    logic signed [DW-1:0]   s2_d_q;
    logic [AW-1:0]          s2_a_q;

    logic                   s3_vld_q;
    logic [ADDR_WIDTH-1:0]  s3_addr_q;
    logic signed [WW-1:0]   s3_w_q;
    logic signed [PW-1:0]   s3_p_q;

    logic                   rd_fire;
    logic                   accept;
    logic [DW-1:0]          d_sel;
    logic [AW-1:0]          a_sel;
    logic signed [PW-1:0]   prod;
    logic signed [WW-1:0]   upd_w;
    logic                   ovf;

    assign rd_fire = (state_q == ST_RUN);
    assign accept  = (state_q == ST_IDLE) && delta_valid && a_valid;
    assign d_sel   = delta_q[n_q * DW +: DW];
    assign a_sel   = a_q[i_q * AW +: AW];

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        i_d     = i_q;
        delta_d = delta_q;
        a_d     = a_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RUN;
                    delta_d = delta;
                    a_d     = a;
                    k_d     = '0;
                    n_d     = '0;
                    i_d     = '0;
                end
            end
            ST_RUN: begin
                k_d = k_q + ADDR_WIDTH'(1);
                if (i_q == IW'(INPUT_NUM - 1)) begin
                    i_d = '0;
                    n_d = n_q + NW'(1);
                end else begin
                    i_d = i_q + IW'(1);
                end
                if (k_q == ADDR_WIDTH'(T - 1)) begin
                    state_d = ST_DRAIN;
                    k_d     = '0;
                    n_d     = '0;
                    i_d     = '0;
                end
            end
            // The last read is still in S2 on the first drain cycle.
            ST_DRAIN: begin
                if (!s2_vld_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            n_q       <= '0;
            i_q       <= '0;
            delta_q   <= '0;
            a_q       <= '0;
            error_q   <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_addr_q <= '0;
            s2_d_q    <= '0;
            s2_a_q    <= '0;
            s3_vld_q  <= 1'b0;
            s3_addr_q <= '0;
            s3_w_q    <= '0;
            s3_p_q    <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            n_q       <= n_d;
            i_q       <= i_d;
            delta_q   <= delta_d;
            a_q       <= a_d;
            error_q   <= error_q | (s3_vld_q & ovf);
            s2_vld_q  <= rd_fire;
            s2_addr_q <= k_q;
            s2_d_q    <= d_sel;
            s2_a_q    <= a_sel;
            s3_vld_q  <= s2_vld_q;
            s3_addr_q <= s2_addr_q;
            s3_w_q    <= w_rd_data;
            s3_p_q    <= prod;
        end
    end

    weight_update_cell #(
        .DELTA_WIDTH  (DW),
        .ACT_WIDTH    (AW),
        .WEIGHT_WIDTH (WW),
        .SHIFT        (FRACTION_WIDTH + LEARN_RATE_SHIFT),
        .PROD_WIDTH   (PW)
    ) u_cell (
        .delta_i  (s2_d_q),
        .act_i    (s2_a_q),
        .prod_o   (prod),
        .prod_i   (s3_p_q),
        .weight_i (s3_w_q),
        .weight_o (upd_w),
        .ovf_o    (ovf)
    );

    // Strobes are gated by rst so a mid-pass reset silences them at once.
    assign delta_ready = (state_q == ST_IDLE) & rst;
    assign a_ready     = (state_q == ST_IDLE) & rst;
    assign w_rd_en     = rd_fire & rst;
    assign w_rd_addr   = k_q;
    assign w_wr_en     = s3_vld_q & rst;
    assign w_wr_addr   = s3_addr_q;
    assign w_wr_data   = s3_vld_q ? upd_w : '0;
    assign done        = (state_q == ST_DONE) & rst;
    assign error       = error_q & rst;

endmodule

// File: tb/tb_weight_updater.sv
// Scoreboard bench for weight_updater: directed passes on a 2x3 layer
// (no shift) and a 1x2 layer with a learning-rate shift of one.
module tb_weight_updater;

    localparam int N   = 2;
    localparam int M   = 3;
    localparam int DW  = 10;
    localparam int AW  = 9;
    localparam int WW  = 16;
    localparam int ADW = 3;
    localparam int T   = N * M;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   vec_cnt = 0;
    int   mis_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT 1: 2x3, shift 0 ----------------
    logic [N*DW-1:0] delta;
    logic            delta_valid = 1'b0;
    logic            delta_ready;
    logic [M*AW-1:0] a;
    logic            a_valid = 1'b0;
    logic            a_ready;
    logic            w_rd_en;
    logic [ADW-1:0]  w_rd_addr;
    logic [WW-1:0]   w_rd_data = '0;
    logic            w_wr_en;
    logic [ADW-1:0]  w_wr_addr;
    logic [WW-1:0]   w_wr_data;
    logic            done;
    logic            error;

    weight_updater #(
        .NEURON_NUM(N), .INPUT_NUM(M), .DELTA_CELL_WIDTH(DW),
        .ACTIVATION_WIDTH(AW), .WEIGHT_CELL_WIDTH(WW),
        .FRACTION_WIDTH(0), .LEARN_RATE_SHIFT(0), .ADDR_WIDTH(ADW)
    ) u_dut (
        .clk(clk), .rst(rst),
        .delta(delta), .delta_valid(delta_valid), .delta_ready(delta_ready),
        .a(a), .a_valid(a_valid), .a_ready(a_ready),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
        .done(done), .error(error)
    );

    // ---------------- DUT 2: 1x2, shift 1 ----------------
    logic [DW-1:0]   delta2 = '0;
    logic            delta2_valid = 1'b0;
    logic            delta2_ready;
    logic [2*AW-1:0] a2 = '0;
    logic            a2_valid = 1'b0;
    logic            a2_ready;
    logic            w2_rd_en;
    logic [0:0]      w2_rd_addr;
    logic [WW-1:0]   w2_rd_data = '0;
    logic            w2_wr_en;
    logic [0:0]      w2_wr_addr;
    logic [WW-1:0]   w2_wr_data;
    logic            done2;
    logic            error2;

    weight_updater #(
        .NEURON_NUM(1), .INPUT_NUM(2), .DELTA_CELL_WIDTH(DW),
        .ACTIVATION_WIDTH(AW), .WEIGHT_CELL_WIDTH(WW),
        .FRACTION_WIDTH(0), .LEARN_RATE_SHIFT(1), .ADDR_WIDTH(1)
    ) u_dut2 (
        .clk(clk), .rst(rst),
        .delta(delta2), .delta_valid(delta2_valid), .delta_ready(delta2_ready),
        .a(a2), .a_valid(a2_valid), .a_ready(a2_ready),
        .w_rd_en(w2_rd_en), .w_rd_addr(w2_rd_addr), .w_rd_data(w2_rd_data),
        .w_wr_en(w2_wr_en), .w_wr_addr(w2_wr_addr), .w_wr_data(w2_wr_data),
        .done(done2), .error(error2)
    );

    // ---------------- weight memories ----------------
    logic [WW-1:0] mem [8];
    logic [WW-1:0] ld_img [8];
    logic          ld = 1'b0;
    logic [WW-1:0] mem2 [2];
    logic          ld2 = 1'b0;

    always @(posedge clk) begin
        if (ld) begin
            for (int j = 0; j < 8; j++) mem[j] <= ld_img[j];
        end else if (w_wr_en) begin
            mem[w_wr_addr] <= w_wr_data;
        end
        if (w_rd_en) w_rd_data <= mem[w_rd_addr];
    end

    always @(posedge clk) begin
        if (ld2) begin
            mem2[0] <= 16'd10;
            mem2[1] <= 16'd10;
        end else if (w2_wr_en) begin
            mem2[w2_wr_addr] <= w2_wr_data;
        end
        if (w2_rd_en) w2_rd_data <= mem2[w2_rd_addr];
    end

    function automatic void chk(input string nm, input int act, input int exp);
        vec_cnt = vec_cnt + 1;
        if (act != exp) begin
            mis_cnt = mis_cnt + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // ---------------- scoreboards ----------------
    exp_t q1[$];
    exp_t q2[$];

    always @(negedge clk) begin : mon1
        exp_t e;
        if (w_wr_en) begin
            if (q1.size() == 0) begin
                chk("wr_unexpected", int'(w_wr_addr), -1);
            end else begin
                e = q1.pop_front();
                chk("wr_addr", int'(w_wr_addr), e.addr);
                chk("wr_data", int'($signed(w_wr_data)), e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (w2_wr_en) begin
            if (q2.size() == 0) begin
                chk("wr2_unexpected", int'(w2_wr_addr), -1);
            end else begin
                e = q2.pop_front();
                chk("wr2_addr", int'(w2_wr_addr), e.addr);
                chk("wr2_data", int'($signed(w2_wr_data)), e.data);
                chk("wr2_cycle", cyc, e.cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int img [6];

    task automatic push_img(input int acc);
        for (int k = 0; k < T; k++) q1.push_back('{addr: k, data: img[k], cyc: acc + k + 3});
    endtask

    task automatic load_all(input int v);
        for (int j = 0; j < 8; j++) ld_img[j] = WW'(v);
        ld = 1'b1;
        @(posedge clk); #1;
        ld = 1'b0;
    endtask

    // Runs one pass; lead = cycles a_valid precedes delta_valid,
    // hold = leave both valids high after the accept.
    task automatic run_pass(input logic [N*DW-1:0] d, input logic [M*AW-1:0] av,
                            input int lead, input bit hold);
        int acc;
        delta = d;
        a = av;
        a_valid = 1'b1;
        delta_valid = (lead == 0);
        for (int j = 0; j < lead; j++) begin
            @(negedge clk);
            chk("join_wait_rd_en", int'(w_rd_en), 0);
            chk("join_wait_a_ready", int'(a_ready), 1);
            @(posedge clk); #1;
        end
        delta_valid = 1'b1;
        @(negedge clk);
        chk("accept_delta_ready", int'(delta_ready), 1);
        chk("accept_a_ready", int'(a_ready), 1);
        acc = cyc;
        push_img(acc);
        @(posedge clk); #1;
        if (!hold) begin
            delta_valid = 1'b0;
            a_valid = 1'b0;
        end
        for (int c = 1; c <= T; c++) begin
            @(negedge clk);
            chk("rd_en", int'(w_rd_en), 1);
            chk("rd_addr", int'(w_rd_addr), c - 1);
            if (c == 1) begin
                chk("ready_drop_delta", int'(delta_ready), 0);
                chk("ready_drop_a", int'(a_ready), 0);
            end
        end
        for (int c = T + 1; c <= T + 2; c++) begin
            @(negedge clk);
            chk("drain_rd_en", int'(w_rd_en), 0);
            chk("drain_done", int'(done), 0);
        end
        @(negedge clk);
        chk("done_pulse", int'(done), 1);
        chk("done_cycle", cyc, acc + T + 3);
        @(negedge clk);
        chk("done_clear", int'(done), 0);
        chk("ready_back", int'(delta_ready & a_ready), 1);
        chk("scoreboard_drained", q1.size(), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin : stim
        int acc;
        delta = '0;
        a = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_delta_ready", int'(delta_ready), 0);
        chk("rst_a_ready", int'(a_ready), 0);
        chk("rst_rd_en", int'(w_rd_en), 0);
        chk("rst_wr_en", int'(w_wr_en), 0);
        chk("rst_rd_addr", int'(w_rd_addr), 0);
        chk("rst_wr_addr", int'(w_wr_addr), 0);
        chk("rst_wr_data", int'(w_wr_data), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Basic pass: delta {3,-2}, a {1,2,4}, all weights 10.
        load_all(10);
        img = '{13, 16, 22, 8, 6, 2};
        run_pass({10'h3FE, 10'd3}, {9'd4, 9'd2, 9'd1}, 0, 1'b0);
        chk("basic_error", int'(error), 0);

        // Saturation at both rails.
        ld_img = '{16'h7FFF, 16'h0, 16'h0, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0};
        ld = 1'b1;
        @(posedge clk); #1;
        ld = 1'b0;
        img = '{32767, 0, 0, -32768, 0, 0};
        run_pass({10'h3FF, 10'd1}, {9'd0, 9'd0, 9'd1}, 0, 1'b0);
        chk("sat_error", int'(error), 1);

        // Clean pass keeps the sticky flag.
        load_all(10);
        img = '{13, 16, 22, 8, 6, 2};
        run_pass({10'h3FE, 10'd3}, {9'd4, 9'd2, 9'd1}, 0, 1'b0);
        chk("sticky_error", int'(error), 1);

        // a_valid leads delta_valid by five cycles.
        load_all(10);
        run_pass({10'h3FE, 10'd3}, {9'd4, 9'd2, 9'd1}, 5, 1'b0);

        // Reset on cycle 4 of a pass: only address 0 is written.
        load_all(10);
        delta = {10'h3FE, 10'd3};
        a = {9'd4, 9'd2, 9'd1};
        delta_valid = 1'b1;
        a_valid = 1'b1;
        @(negedge clk);
        acc = cyc;
        q1.push_back('{addr: 0, data: 13, cyc: acc + 3});
        @(posedge clk); #1;
        delta_valid = 1'b0;
        a_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_wr_en", int'(w_wr_en), 0);
        chk("midrst_rd_en", int'(w_rd_en), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("postrst_done", int'(done), 0);
            chk("postrst_wr_en", int'(w_wr_en), 0);
        end
        chk("postrst_error", int'(error), 0);
        chk("postrst_ready", int'(delta_ready & a_ready), 1);
        chk("postrst_wr_data", int'(w_wr_data), 0);
        chk("postrst_rd_addr", int'(w_rd_addr), 0);
        chk("postrst_sb_empty", q1.size(), 0);

        load_all(10);
        img = '{13, 16, 22, 8, 6, 2};
        run_pass({10'h3FE, 10'd3}, {9'd4, 9'd2, 9'd1}, 0, 1'b0);
        chk("recover_error", int'(error), 0);

        // Back-to-back: second pass accepted on cycle T+4.
        load_all(10);
        img = '{13, 16, 22, 8, 6, 2};
        run_pass({10'h3FE, 10'd3}, {9'd4, 9'd2, 9'd1}, 0, 1'b1);
        acc = cyc;
        img = '{16, 22, 34, 6, 2, -6};
        push_img(acc);
        @(posedge clk); #1;
        delta_valid = 1'b0;
        a_valid = 1'b0;
        @(negedge clk);
        chk("b2b_rd_en", int'(w_rd_en), 1);
        chk("b2b_rd_addr", int'(w_rd_addr), 0);
        chk("b2b_rd_cycle", cyc, acc + 1);
        begin : wait_done
            bit seen;
            seen = 1'b0;
            for (int j = 0; j < 20 && !seen; j++) begin
                @(negedge clk);
                if (done) begin
                    seen = 1'b1;
                    chk("b2b_done_cycle", cyc, acc + T + 3);
                end
            end
            if (!seen) chk("b2b_done_timeout", 0, 1);
        end
        chk("b2b_sb_empty", q1.size(), 0);

        // Learning-rate shift with floor rounding: 10 + floor(-1/2), 10 + floor(-3/2).
        ld2 = 1'b1;
        @(posedge clk); #1;
        ld2 = 1'b0;
        delta2 = 10'h3FF;
        a2 = {9'd3, 9'd1};
        delta2_valid = 1'b1;
        a2_valid = 1'b1;
        @(negedge clk);
        acc = cyc;
        q2.push_back('{addr: 0, data: 9, cyc: acc + 3});
        q2.push_back('{addr: 1, data: 8, cyc: acc + 4});
        @(posedge clk); #1;
        delta2_valid = 1'b0;
        a2_valid = 1'b0;
        begin : wait_done2
            bit seen;
            seen = 1'b0;
            for (int j = 0; j < 20 && !seen; j++) begin
                @(negedge clk);
                if (done2) begin
                    seen = 1'b1;
                    chk("shift_done_cycle", cyc, acc + 5);
                end
            end
            if (!seen) chk("shift_done_timeout", 0, 1);
        end
        chk("shift_error", int'(error2), 0);
        chk("shift_sb_empty", q2.size(), 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule

// File: doc/weight_updater.md
# weight_updater

Backpropagation stage directly downstream of the delta-producing stage: accepts one delta vector (NEURON_NUM signed cells) and the previous layer's activation vector (INPUT_NUM unsigned cells), then applies the outer-product gradient step to the layer's weight memory. It walks every weight once, in order, through a read-modify-write pipeline and pulses `done` when the pass is complete. Overflow is flagged on a sticky `error` output.

## Interface
- NEURON_NUM, 5, number of neurons (delta cells, weight rows)
- INPUT_NUM, 5, number of inputs per neuron (activation cells, weight columns)
- DELTA_CELL_WIDTH, 10, signed width of each delta cell
- ACTIVATION_WIDTH, 9, unsigned width of each activation cell
- WEIGHT_CELL_WIDTH, 16, signed width of each stored weight
- FRACTION_WIDTH, 0, fixed-point fraction bits shared by delta and activation
- LEARN_RATE_SHIFT, 3, learning rate expressed as 2^-LEARN_RATE_SHIFT
- ADDR_WIDTH, clog2(NEURON_NUM*INPUT_NUM), weight memory address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- delta  in  NEURON_NUM*DELTA_CELL_WIDTH  delta vector, cell n at [n*DELTA_CELL_WIDTH +: DELTA_CELL_WIDTH]
- delta_valid / delta_ready  in / out  1  handshake for delta
- a  in  INPUT_NUM*ACTIVATION_WIDTH  previous-layer activations
- a_valid / a_ready  in / out  1  handshake for a
- w_rd_en  out  1  weight memory read strobe
- w_rd_addr  out  ADDR_WIDTH  read address
- w_rd_data  in  WEIGHT_CELL_WIDTH  read data, valid exactly 1 cycle after w_rd_en
- w_wr_en  out  1  write strobe
- w_wr_addr  out  ADDR_WIDTH  write address
- w_wr_data  out  WEIGHT_CELL_WIDTH  updated weight
- done  out  1  one-cycle pulse at end of pass
- error  out  1  sticky saturation flag

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: delta_ready = a_ready = 1 (0 while rst is asserted). Join: both vectors are captured only in the cycle when delta_valid & a_valid; no partial acceptance, and a lone valid waits. On capture go to RUN, index k=0.
- RUN: each cycle, w_rd_en=1, w_rd_addr=k, k++. Address k = n*INPUT_NUM + i (neuron-major). After k = NEURON_NUM*INPUT_NUM-1, go to DRAIN.
- Pipeline: S1 read issue; S2 w_rd_data arrives, product p = delta[n] * a[i] (signed, DELTA_CELL_WIDTH+ACTIVATION_WIDTH+1 bits, a zero-extended) registered with w; S3 u = p >>> (FRACTION_WIDTH+LEARN_RATE_SHIFT) (arithmetic, floor), s = w + u, saturated to signed WEIGHT_CELL_WIDTH, driven on w_wr_data with w_wr_en=1, w_wr_addr=k.
- Any saturation sets error; error holds until reset.
- DRAIN: flush the last 2 pipeline entries. DONE: done=1 for one cycle, then IDLE.
- Each address is read and written exactly once per pass, with no read-after-write hazard.
- Reset mid-pass: the pass is aborted, no further w_wr_en, all state cleared.

## Timing
- Reset values: delta_ready=0, a_ready=0, w_rd_en=0, w_wr_en=0, addresses 0, w_wr_data 0, done=0, error=0.
- Accept at cycle 0. Reads are on cycles 1..T with T = NEURON_NUM*INPUT_NUM. The write for address k is on cycle k+3. Last write is on cycle T+2, done on cycle T+3, and ready is high again on cycle T+4.
- Throughput is one weight per cycle. No stalls: the memory is assumed always available.
- Ready is low from cycle 1 until IDLE.

## Structure
- Shared package: the clog2 function, a saturate(value, width) function, and the state enum localparams.
- One sub-module, `weight_update_cell`: combinational product, shift, add and saturate with an overflow out. The FSM, counters and pipeline registers live in the top.

## Test plan
- N=2, M=3, shifts 0, all weights 10, delta={3,-2}, a={1,2,4} -> writes to addr 0..5 = 13,16,22,8,6,2; done on cycle 9; error=0.
- Weight 32767, delta=1, a=1, shifts 0 -> write 32767, error=1 and stays 1 through the next clean pass; weight -32768 with delta=-1 -> -32768.
- delta=-1, a=1, LEARN_RATE_SHIFT=1 -> u=-1 (floor), weight 10 -> 9.
- a_valid high 5 cycles before delta_valid -> no read until delta_valid, both readies drop together the cycle after the joint accept.
- rst low on cycle 4 of a pass -> no w_wr_en afterward, done never pulses, all outputs at reset values, next pass runs normally.
- Back-to-back: both valids held high -> second pass accepted on cycle T+4, reads addr 0 again on cycle T+5.
